enc_period_quad_avg: RTL
========================

Name: enc_period_quad_avg

Overview:
Parametrised quadrature encoder period estimator, the successor to the per-edge period counters.
- Fully synchronous to clk_fast: A/B are synchronised and edge-detected internally, with no derived clocks.
- Decodes direction, measures clk_fast cycles between consecutive quadrature edges and keeps a moving-window sum of the last 2^AVG_LOG2 periods.
- Reports the larger of the latched period and the elapsed time since the last edge.
- Sits between the encoder pins and the register file feeding velocity estimation.

Parameters:
W, 22, counter/period width; saturation value MAX = 2^W-1
AVG_LOG2, 2, log2 of averaging window depth D = 2^AVG_LOG2 (range 0..4)

Ports:
clk_fast  in  1  counting clock; all logic on posedge
reset  in  1  asynchronous, active-low
a  in  1  raw encoder channel A (asynchronous)
b  in  1  raw encoder channel B (asynchronous)
clr_err  in  1  synchronous pulse, clears err
edge_stb  out  1  one-cycle pulse on each accepted quadrature edge
dir  out  1  0 = A leads B, 1 = B leads A
dir_changed  out  1  set on reversal edge, cleared at next same-direction edge
period  out  W  latched cycles between last two edges
period_est  out  W  max(period, run_cnt)
run_cnt  out  W  cycles since last edge, saturating
avg_sum  out  W+AVG_LOG2  sum of last D valid periods
avg_valid  out  1  window holds D valid periods
sat  out  1  period_est == MAX
err  out  1  sticky illegal-transition flag

Behaviour:
Reset
- Reset (async, low) clears every register at any time, including mid-window.
- Outputs after reset: period = MAX, run_cnt = MAX, period_est = MAX, sat = 1, avg_sum = 0, avg_valid = 0, dir = 0, dir_changed = 0, err = 0, edge_stb = 0.
- Internal have_edge = 0 and fill = 0.
- Sync flops reset to 0, so a high pin produces one spurious edge after reset. That edge is treated as the first edge (see below).

Input path and decode
- A and B each pass through a 2-flop synchroniser, then a previous-state register.
- Edge: exactly one of A or B differs from its previous value. edge_stb asserts 3 cycles after a pin change.
- Direction from the (prev, cur) Gray transition:
  - 00->10->11->01->00 gives dir = 0.
  - The reverse sequence gives dir = 1.
- Illegal transition (both channels change in one cycle): err <= 1, no edge_stb, run_cnt continues, dir unchanged, previous-state register is updated.
- err and clr_err in the same cycle: set wins.

Counter
- Every cycle without an edge: run_cnt <= run_cnt + 1, saturating at MAX.
- On an edge cycle: period <= run_cnt and run_cnt <= 1. For edges P cycles apart, period = P.

Edge classification
- First edge: the first edge after reset, or any edge whose direction differs from the previous edge's direction.
  - period <= MAX.
  - History is flushed: fill <= 0, avg_sum <= 0, avg_valid <= 0.
  - Nothing is pushed into the window.
  - dir_changed <= 1 on a reversal; it stays 0 on the first edge after reset.
  - have_edge <= 1.
- Normal edge: push period into a D-deep shift register.
  - avg_sum <= avg_sum + new - oldest, where oldest counts as 0 while fill < D.
  - fill saturates at D; avg_valid = (fill == D), registered in the same cycle as the push.
  - dir_changed <= 0.
- A saturated period (MAX) is pushed as MAX. Width W+AVG_LOG2 guarantees avg_sum never overflows.

Derived outputs
- period_est and sat are registered one cycle after period/run_cnt update.

Test Plan:
- Reset, then 6 forward edges (A leads B) spaced 100 cycles -> edge_stb ×6, dir = 0, period = 100 from edge 2, avg_sum = 400 and avg_valid = 1 after edge 5 (W = 22, D = 4).
- Same as above, then hold pins 5,000,000 cycles -> run_cnt, period_est and sat saturate at 0x3FFFFF, period stays 100, avg_sum stays 400.
- Forward edges at 100 cycles, then a reverse edge -> dir = 1, dir_changed = 1, period = MAX, avg_valid = 0, avg_sum = 0; next reverse edge at 50 -> dir_changed = 0, period = 50, avg_sum = 50.
- Toggle A and B in the same cycle -> err = 1, no edge_stb, dir unchanged; clr_err pulse -> err = 0; clr_err coincident with a new illegal transition -> err stays 1.
- Assert reset mid-window with fill = 3 -> all outputs at reset values immediately; the first edge afterwards gives period = MAX with no push; the next edge is the first push.
- Edges spaced 1 cycle apart (alternating A/B each cycle) -> edge_stb every cycle, period = 1, avg_sum = 4.

Source files
------------

// File: rtl/enc_period_quad_avg_if.sv
// Encoder pin inputs and period-estimator results, grouped as one bus.
// The master drives pins and clr_err; the estimator is the slave.
interface enc_period_quad_avg_if #(
  parameter int W        = 22,
  parameter int AVG_LOG2 = 2
);
  logic                  a;
  logic                  b;
  logic                  clr_err;
  logic                  edge_stb;
  logic                  dir;
  logic                  dir_changed;
  logic [W-1:0]          period;
  logic [W-1:0]          period_est;
  logic [W-1:0]          run_cnt;
  logic [W+AVG_LOG2-1:0] avg_sum;
  logic                  avg_valid;
  logic                  sat;
  logic                  err;

  modport master (
    output a, b, clr_err,
    input  edge_stb, dir, dir_changed, period, period_est, run_cnt,
           avg_sum, avg_valid, sat, err
  );

  modport slave (
    input  a, b, clr_err,
    output edge_stb, dir, dir_changed, period, period_est, run_cnt,
           avg_sum, avg_valid, sat, err
  );
endinterface

// File: rtl/enc_period_quad_avg.sv
// Quadrature encoder period estimator: synchronises A/B, decodes direction,
// measures edge-to-edge periods and keeps a moving sum of the last 2^AVG_LOG2.
module enc_period_quad_avg #(
  parameter int W        = 22,
  parameter int AVG_LOG2 = 2
) (
  input  logic                  clk_fast,
  input  logic                  reset,
  enc_period_quad_avg_if.slave  bus
);
  localparam int            DEPTH = 1 << AVG_LOG2;
  localparam int            SW    = W + AVG_LOG2;
  localparam int            FW    = AVG_LOG2 + 1;
  localparam logic [W-1:0]  MAX   = '1;
  localparam logic [FW-1:0] FULL  = FW'(DEPTH);

  // pin pairs are packed as {a, b}
  logic [1:0]                s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic                      edge_stb_q, edge_stb_d, dir_q, dir_d;
  logic                      dir_changed_q, dir_changed_d, have_edge_q, have_edge_d;
  logic                      err_q, err_d, avg_valid_q, avg_valid_d, sat_q, sat_d;
  logic [W-1:0]              period_q, period_d, run_cnt_q, run_cnt_d;
  logic [W-1:0]              period_est_q, period_est_d;
  logic [SW-1:0]             avg_sum_q, avg_sum_d;
  logic [FW-1:0]             fill_q, fill_d;
  logic [DEPTH-1:0][W-1:0]   hist_q, hist_d;

  logic [1:0]   chg;
  logic         edge_det, illegal, new_dir, first;
  logic [W-1:0] oldest;

  always_comb begin
    s1_d   = {bus.a, bus.b};
    s2_d   = s1_q;
    prev_d = s2_q;

    chg      = s2_q ^ prev_q;
    edge_det = (chg == 2'b01) || (chg == 2'b10);
    illegal  = (chg == 2'b11);
    // forward Gray steps always have prev A equal to current B
    new_dir  = prev_q[1] ^ s2_q[0];
    first    = !have_edge_q || (new_dir != dir_q);
    oldest   = (fill_q == FULL) ? hist_q[DEPTH-1] : '0;

    edge_stb_d    = edge_det;
    err_d         = illegal | (err_q & ~bus.clr_err);
    dir_d         = dir_q;
    dir_changed_d = dir_changed_q;
    have_edge_d   = have_edge_q;
    period_d      = period_q;
    run_cnt_d     = (run_cnt_q == MAX) ? MAX : run_cnt_q + W'(1);
    avg_sum_d     = avg_sum_q;
    avg_valid_d   = avg_valid_q;
    fill_d        = fill_q;
    hist_d        = hist_q;

    if (edge_det) begin
      period_d    = run_cnt_q;
      run_cnt_d   = W'(1);
      dir_d       = new_dir;
      have_edge_d = 1'b1;
      if (first) begin
        period_d      = MAX;
        fill_d        = '0;
        avg_sum_d     = '0;
        avg_valid_d   = 1'b0;
        dir_changed_d = have_edge_q;
      end else begin
        hist_d[0] = run_cnt_q;
        for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
        avg_sum_d     = avg_sum_q + SW'(run_cnt_q) - SW'(oldest);
        fill_d        = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
        avg_valid_d   = (fill_d == FULL);
        dir_changed_d = 1'b0;
      end
    end

    period_est_d = (period_q > run_cnt_q) ? period_q : run_cnt_q;
    sat_d        = (period_est_d == MAX);
  end

  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      s1_q          <= '0;
      s2_q          <= '0;
      prev_q        <= '0;
      edge_stb_q    <= 1'b0;
      err_q         <= 1'b0;
      dir_q         <= 1'b0;
      dir_changed_q <= 1'b0;
      have_edge_q   <= 1'b0;
      period_q      <= MAX;
      run_cnt_q     <= MAX;
      avg_sum_q     <= '0;
      avg_valid_q   <= 1'b0;
      fill_q        <= '0;
      hist_q        <= '0;
      period_est_q  <= MAX;
      sat_q         <= 1'b1;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      prev_q        <= prev_d;
      edge_stb_q    <= edge_stb_d;
      err_q         <= err_d;
      dir_q         <= dir_d;
      dir_changed_q <= dir_changed_d;
      have_edge_q   <= have_edge_d;
      period_q      <= period_d;
      run_cnt_q     <= run_cnt_d;
      avg_sum_q     <= avg_sum_d;
      avg_valid_q   <= avg_valid_d;
      fill_q        <= fill_d;
      hist_q        <= hist_d;
      period_est_q  <= period_est_d;
      sat_q         <= sat_d;
    end
  end

  assign bus.edge_stb    = edge_stb_q;
  assign bus.dir         = dir_q;
  assign bus.dir_changed = dir_changed_q;
  assign bus.period      = period_q;
  assign bus.period_est  = period_est_q;
  assign bus.run_cnt     = run_cnt_q;
  assign bus.avg_sum     = avg_sum_q;
  assign bus.avg_valid   = avg_valid_q;
  assign bus.sat         = sat_q;
  assign bus.err         = err_q;
endmodule
